// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory controller: sub-word loads/stores with extension,
// request checking and a post-reset clear sequencer that zeroes the array.
module dmc_lane #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module data_memory_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              unsignedLoad,
    output logic [DATA_W-1:0] readData,
    output logic              readValid,
    output logic              memErr,
    output logic              busy
);
    localparam int NUM_LANES = DATA_W / 8;
    localparam int LANE_BITS = $clog2(NUM_LANES);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int TOP       = IDX_W + LANE_BITS;

    typedef enum logic {CLEAR, READY} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]     idx;
        logic [LANE_BITS-1:0] lane;
        logic                 oor;
        logic                 mis;
    } dec_t;

    state_t     state;
    logic [IDX_W-1:0] ptr;
    dec_t       dec;
    logic       clearing, bad, ld_ok, st_ok;

    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] wd;
    logic [NUM_LANES-1:0][7:0] rd_bytes;
    logic [DATA_W-1:0]         rd_word, shifted, ld_val;

    assign dec.idx  = address[TOP-1:LANE_BITS];
    assign dec.lane = address[LANE_BITS-1:0];

    generate
        if (ADDR_W > TOP) begin : g_oor
            assign dec.oor = |address[ADDR_W-1:TOP];
        end else begin : g_no_oor
            assign dec.oor = 1'b0;
        end
    endgenerate

    // Non-power-of-two lane counts leave some lane codes unusable.
    always_comb begin
        dec.mis = 1'b1;
        case (size)
            2'b00:   dec.mis = (32'(dec.lane) >= NUM_LANES);
            2'b01:   dec.mis = address[0] | (32'(dec.lane) + 2 > NUM_LANES);
            2'b10:   dec.mis = |dec.lane;
            default: dec.mis = 1'b1;
        endcase
    end

    assign clearing = (state == CLEAR);
    assign bad      = (MemRead & MemWrite) | dec.mis | dec.oor;
    assign ld_ok    = !clearing & MemRead & !bad;
    assign st_ok    = !clearing & MemWrite & !bad;

    // Per-lane enables and store data steering; halfwords always start on an even lane.
    always_comb begin
        be = '0;
        wd = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            case (size)
                2'b00: begin
                    be[i] = (LANE_BITS'(i) == dec.lane);
                    wd[i] = writeData[7:0];
                end
                2'b01: begin
                    be[i] = (LANE_BITS'(i) == dec.lane) || (LANE_BITS'(i) == dec.lane + 1'b1);
                    wd[i] = writeData[8*(i%2) +: 8];
                end
                default: begin
                    be[i] = 1'b1;
                    wd[i] = writeData[8*i +: 8];
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            dmc_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
                .clk   (clk),
                .we    (rst & (clearing | (st_ok & be[g]))),
                .waddr (clearing ? ptr : dec.idx),
                .wdata (clearing ? 8'h00 : wd[g]),
                .raddr (dec.idx),
                .rdata (rd_bytes[g])
            );
        end
    endgenerate

    assign rd_word = rd_bytes;
    assign shifted = rd_word >> {dec.lane, 3'b000};

    always_comb begin
        case (size)
            2'b00:   ld_val = {{(DATA_W-8){~unsignedLoad & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_val = {{(DATA_W-16){~unsignedLoad & shifted[15]}}, shifted[15:0]};
            default: ld_val = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            ptr       <= '0;
            busy      <= 1'b1;
            readData  <= '0;
            readValid <= 1'b0;
            memErr    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    readValid <= 1'b0;
                    memErr    <= 1'b0;
                    ptr       <= ptr + 1'b1;
                    if (ptr == IDX_W'(DEPTH-1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    readValid <= ld_ok;
                    memErr    <= (MemRead | MemWrite) & bad;
                    if (ld_ok) readData <= ld_val;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: expected load data queued at issue,
// compared when readValid is sampled.
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, writeData, readData;
    logic        MemRead, MemWrite, unsignedLoad, readValid, memErr, busy;
    logic [1:0]  size;

    int checks = 0;
    int failures = 0;
    logic [31:0] sbq[$];
    logic [31:0] last_rd;

    data_memory_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .address(address), .writeData(writeData),
        .MemRead(MemRead), .MemWrite(MemWrite), .size(size),
        .unsignedLoad(unsignedLoad), .readData(readData), .readValid(readValid),
        .memErr(memErr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic u,
                        input logic exp_err, input string tag);
        logic exp_vld;
        logic [31:0] exp;
        exp_vld = rd & ~wr & ~exp_err;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; address = a; writeData = d; size = sz; unsignedLoad = u;
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        chk({tag, "_err"}, {31'd0, memErr}, {31'd0, exp_err});
        chk({tag, "_vld"}, {31'd0, readValid}, {31'd0, exp_vld});
        if (exp_vld) begin
            if (sbq.size() == 0) begin
                chk({tag, "_sbq"}, 32'd0, 32'd1);
            end else begin
                exp = sbq.pop_front();
                chk({tag, "_data"}, readData, exp);
                last_rd = exp;
            end
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                        input logic [31:0] exp, input string tag);
        sbq.push_back(exp);
        step(1'b1, 1'b0, a, 32'd0, sz, u, 1'b0, tag);
    endtask

    task automatic count_clear(input string tag);
        int cnt;
        logic spur;
        cnt = 0;
        spur = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (readValid | memErr) spur = 1'b1;
            if (cnt == 2) MemRead = 1'b0;
            if (!busy) break;
        end
        chk({tag, "_cycles"}, 32'(cnt), 32'd64);
        chk({tag, "_quiet"}, {31'd0, spur}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; address = '0; writeData = '0; MemRead = 1'b0; MemWrite = 1'b0;
        size = 2'b10; unsignedLoad = 1'b0; last_rd = '0;

        // 1: reset, clear sequence, requests ignored while clearing
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", readData, 32'd0);
        chk("rst_vld", {31'd0, readValid}, 32'd0);
        chk("rst_err", {31'd0, memErr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1; MemRead = 1'b1; address = 32'h5; size = 2'b10;
        count_clear("clr1");
        load(32'h0C, 2'b10, 1'b0, 32'h0000_0000, "t1_ld0c");

        // 2: store then back-to-back load
        step(1'b0, 1'b1, 32'h18, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, "t2_st");
        load(32'h18, 2'b10, 1'b0, 32'hDEADBEEF, "t2_ld");
        step(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, "t2_idle");
        chk("t2_hold", readData, 32'hDEADBEEF);

        // 3: byte merge and byte extension
        step(1'b0, 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 1'b0, "t3_stw");
        step(1'b0, 1'b1, 32'h21, 32'h0000_00AA, 2'b00, 1'b0, 1'b0, "t3_stb");
        load(32'h20, 2'b10, 1'b0, 32'h1122AA44, "t3_ldw");
        load(32'h21, 2'b00, 1'b0, 32'hFFFFFFAA, "t3_ldbs");
        load(32'h21, 2'b00, 1'b1, 32'h000000AA, "t3_ldbu");

        // 4: halfword extension
        step(1'b0, 1'b1, 32'h30, 32'h80017FFF, 2'b10, 1'b0, 1'b0, "t4_st");
        load(32'h32, 2'b01, 1'b0, 32'hFFFF8001, "t4_ldhs");
        load(32'h30, 2'b01, 1'b1, 32'h00007FFF, "t4_ldhu");
        load(32'h32, 2'b01, 1'b1, 32'h00008001, "t4_ldhu2");
        load(32'h33, 2'b00, 1'b0, 32'hFFFFFF80, "t4_ldb3");

        // 5: rejected requests
        step(1'b1, 1'b0, 32'h06, 32'h0, 2'b10, 1'b0, 1'b1, "e_ld06");
        chk("e_ld06_hold", readData, last_rd);
        step(1'b0, 1'b1, 32'h11, 32'hBEEF, 2'b01, 1'b0, 1'b1, "e_st11");
        chk("e_st11_hold", readData, last_rd);
        load(32'h10, 2'b10, 1'b0, 32'h0, "e_st11_rl");
        step(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 1'b1, "e_sz3");
        chk("e_sz3_hold", readData, last_rd);
        step(1'b0, 1'b1, 32'h24, 32'h55, 2'b11, 1'b0, 1'b1, "e_sz3st");
        load(32'h24, 2'b10, 1'b0, 32'h0, "e_sz3_rl");
        step(1'b0, 1'b1, 32'h100, 32'h12345678, 2'b10, 1'b0, 1'b1, "e_oor");
        chk("e_oor_hold", readData, last_rd);
        load(32'h00, 2'b10, 1'b0, 32'h0, "e_oor_rl");
        step(1'b1, 1'b1, 32'h18, 32'h0, 2'b10, 1'b0, 1'b1, "e_both");
        chk("e_both_hold", readData, last_rd);
        load(32'h18, 2'b10, 1'b0, 32'hDEADBEEF, "e_both_rl");
        step(1'b0, 1'b0, 32'h06, 32'h0, 2'b11, 1'b0, 1'b0, "idle_bad");

        // 6: reset together with a load, then reset mid-clear
        @(negedge clk);
        rst = 1'b0; MemRead = 1'b1; address = 32'h18; size = 2'b10;
        @(posedge clk); #1;
        MemRead = 1'b0;
        chk("t6_rst_vld", {31'd0, readValid}, 32'd0);
        chk("t6_rst_data", readData, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_mid_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        count_clear("clr2");
        load(32'h18, 2'b10, 1'b0, 32'h0, "t6_zeroed");
        load(32'h20, 2'b10, 1'b0, 32'h0, "t6_zeroed2");

        chk("sbq_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised successor to the single-port word data memory used by the KGP-RISC datapath. It adds byte, halfword and word access with sign or zero extension, and a registered read with a valid strobe. It flags misaligned, out-of-range and conflicting requests. After reset it runs a hardware clear sequencer that zeroes the array. It sits between the EX/MEM stage and the data array, and is driven by MemRead and MemWrite from the control unit.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 16.
DEPTH, 64, number of words; must be a power of two.
ADDR_W, 32, width of the byte address input.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 means reset.
address  in  ADDR_W  byte address.
writeData  in  DATA_W  store data, right-aligned for byte and halfword accesses.
MemRead  in  1  load request, valid in the current cycle.
MemWrite  in  1  store request, valid in the current cycle.
size  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
unsignedLoad  in  1  1 = zero-extend loads, 0 = sign-extend loads.
readData  out  DATA_W  registered load result.
readValid  out  1  one-cycle pulse; readData is updated in the same cycle.
memErr  out  1  one-cycle pulse for a rejected request.
busy  out  1  high while the clear sequencer runs.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - readData = 0, readValid = 0, memErr = 0, busy = 1.
  - Clear pointer = 0, FSM state = CLEAR.
  - Array contents are not touched during reset.
- FSM has two states, CLEAR and READY.
  - CLEAR: on each clk edge with rst = 1, write 0 to word[ptr], then ptr = ptr + 1.
  - When ptr = DEPTH-1 has been written, go to READY and drop busy, so busy is high for DEPTH cycles after reset release.
  - In CLEAR, MemRead and MemWrite are ignored: no access, no readValid, no memErr.
  - Reset asserted mid-clear restarts the sequence at ptr = 0.
- Address decode:
  - Word index = address[log2(DEPTH)+1:2]; byte lane = address[1:0].
  - out-of-range = any address bit above log2(DEPTH)+1 is 1.
- Request checks in READY. A request is rejected, with memErr = 1 on the next cycle, no array change and readData held, if any of these holds:
  - MemRead and MemWrite are both high;
  - size = 11;
  - a halfword access with address[0] = 1;
  - a word access with address[1:0] ≠ 00;
  - the address is out of range.
  An idle cycle (neither request high) never raises memErr.
- Store (MemWrite = 1, accepted):
  - Written on the same clk edge.
  - Byte: only lane address[1:0] takes writeData[7:0].
  - Halfword: the lanes selected by address[1] take writeData[15:0].
  - Word: the full word is written.
  - Unselected lanes are preserved, using per-byte write enables with no read-modify-write cycle.
- Load (MemRead = 1, accepted):
  - The array is read on edge N; readData and readValid update at edge N+1 (1-cycle latency).
  - The selected byte or half is shifted to bit 0, then extended by unsignedLoad.
  - readData holds its value until the next accepted load.
- Back-to-back: a store at edge N followed by a load of the same address at edge N+1 returns the new data.
- Throughput: one request per cycle, with no stall in READY.
- readValid and memErr are never high in the same cycle.
- For DATA_W > 32, each additional 16-bit step extends the halfword lane selection, and size 10 always means a full DATA_W word.

Test Plan:
1. rst = 0 for 2 cycles, then rst = 1 → busy stays high for exactly 64 cycles; a MemRead at address 5 issued during CLEAR gives no readValid and no memErr. After busy falls, a word load at 0x0C returns 0x00000000.
2. Word store of 0xDEADBEEF at 0x18, then word load at 0x18 on the next cycle → readValid pulses one cycle after the load with readData = 0xDEADBEEF.
3. Store word 0x11223344 at 0x20, then byte store 0xAA at 0x21. Then:
   - word load at 0x20 → readData = 0x1122AA44;
   - signed byte load at 0x21 → readData = 0xFFFFFFAA;
   - unsigned byte load at 0x21 → readData = 0x000000AA.
4. Store word 0x8001_7FFF at 0x30. Then:
   - signed halfword load at 0x32 → readData = 0xFFFF8001;
   - unsigned halfword load at 0x30 → readData = 0x00007FFF.
5. Each of these pulses memErr once, leaves readData unchanged and leaves memory unchanged (checked by reload):
   - word load at 0x06;
   - halfword store at 0x11;
   - size = 11;
   - address 0x100 with DEPTH = 64;
   - MemRead and MemWrite both high at 0x18.
6. Reset asserted in the middle of a clear sequence restarts it, with busy high for a further 64 cycles. Asserting rst in the same cycle as a load gives readValid = 0 and readData = 0.
